vga_axil_slave: RTL
===================

VGA_AXIL_SLAVE -- requirements
Module: vga_axil_slave

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI-lite data width.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 15, AXI-lite address width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from axil_rreq_o assertion to valid axil_rdata_i (range 1-7).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_axi_awvalid  input  1  write address valid.
REQ-007 SHALL have port s_axi_awready  output  1  write address ready.
REQ-008 SHALL have port s_axi_awaddr  input  C_AXI_ADDR_WIDTH  write address.
REQ-009 SHALL have port s_axi_wvalid  input  1  write data valid.
REQ-010 SHALL have port s_axi_wready  output  1  write data ready.
REQ-011 SHALL have port s_axi_wdata  input  C_AXI_DATA_WIDTH  write data.
REQ-012 SHALL have port s_axi_wstrb  input  C_AXI_DATA_WIDTH/8  write strobes.
REQ-013 SHALL have port s_axi_bvalid  output  1  write response valid.
REQ-014 SHALL have port s_axi_bready  input  1  write response ready.
REQ-015 SHALL have port s_axi_bresp  output  2  write response, constant 2'b00 (OKAY).
REQ-016 SHALL have port s_axi_arvalid  input  1  read address valid.
REQ-017 SHALL have port s_axi_arready  output  1  read address ready.
REQ-018 SHALL have port s_axi_araddr  input  C_AXI_ADDR_WIDTH  read address.
REQ-019 SHALL have port s_axi_rvalid  output  1  read data valid.
REQ-020 SHALL have port s_axi_rready  input  1  read data ready.
REQ-021 SHALL have port s_axi_rdata  output  C_AXI_DATA_WIDTH  read data.
REQ-022 SHALL have port s_axi_rresp  output  2  read response, constant 2'b00.
REQ-023 SHALL have port axil_wready_o  output  1  one-cycle write strobe to VGA core.
REQ-024 SHALL have port axil_waddr_o / axil_wdata_o / axil_wstrb_o  output  ADDR/DATA/DATA/8  latched write beat to core.
REQ-025 SHALL have port axil_rreq_o  output  1  read request to core; axil_raddr_o  output  C_AXI_ADDR_WIDTH  read address.
REQ-026 SHALL have port axil_rdata_i  input  C_AXI_DATA_WIDTH  read data from core.

Function
REQ-027 Write FSM SHALL have states W_IDLE, W_ISSUE, W_RESP; read FSM SHALL have R_IDLE, R_WAIT, R_RESP; both run independently, simultaneous read and write permitted.
REQ-028 In W_IDLE, awready SHALL be 1 until an AW beat is latched and wready 1 until a W beat is latched; AW and W accepted in either order or same cycle, each at most once per transaction.
REQ-029 Cycle after both AW and W are latched: W_ISSUE, axil_wready_o=1 for exactly one cycle with axil_waddr_o/wdata_o/wstrb_o holding latched values, full address forwarded unmodified.
REQ-030 Next cycle W_RESP: bvalid=1 held until bvalid&bready; W_IDLE the following cycle; awready/wready SHALL be 0 outside W_IDLE.
REQ-031 In R_IDLE arready SHALL be 1; on arvalid&arready latch araddr to axil_raddr_o and enter R_WAIT.
REQ-032 In R_WAIT axil_rreq_o SHALL be 1 for all READ_LATENCY cycles, axil_raddr_o stable; a 3-bit counter counts them; on its last cycle axil_rdata_i is registered to s_axi_rdata and FSM enters R_RESP.
REQ-033 In R_RESP rvalid=1 and rdata stable until rvalid&rready; R_IDLE next cycle; arready=0 outside R_IDLE.
REQ-034 All outputs SHALL be registered; no combinational path from any AXI input to any output.
REQ-035 bvalid/rvalid held while ready=0 SHALL keep payload stable indefinitely.

Reset
REQ-036 On rstn_i low: both FSMs to IDLE, awready=wready=arready=1 on first cycle after release, bvalid=rvalid=axil_wready_o=axil_rreq_o=0, latched addr/data/strb and rdata=0, counter=0.
REQ-037 Reset mid-transaction SHALL abort it with no core write pulse and no response issued.

Structure
REQ-038 FSM state encodings and OKAY response constant SHALL live in shared package vga_pkg.
REQ-039 Single module, no sub-modules.

Verification
REQ-040 AW and W same cycle, addr 15'h4004, data 32'h0000_0041 -> axil_wready_o pulses 1 cycle later, bvalid next, bresp=00.
REQ-041 W two cycles before AW -> W latched, wready drops, single core pulse after AW, correct addr/data.
REQ-042 Read 15'h2008 with core returning 32'h0000_000F, READ_LATENCY=2 -> rreq high 2 cycles, rvalid with rdata=32'hF.
REQ-043 bready/rready held low 10 cycles -> valid and payload stable, no new AW/AR accepted.
REQ-044 Concurrent read and write -> both complete independently, correct data.
REQ-045 rstn_i asserted during W_RESP and R_WAIT -> all valids/strobes 0, readies 1 after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared encodings for the VGA AXI-lite slave: FSM state types and the AXI
// response code returned on every transaction.
package vga_pkg;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_RESP  = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/vga_axil_slave.sv
// AXI-lite slave front end for the VGA core: turns AW/W beats into a one-cycle
// core write strobe and AR beats into a fixed-latency core read request.
module vga_axil_slave
  import vga_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 15,
  parameter int READ_LATENCY     = 2
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [1:0]                    s_axi_bresp,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          axil_wready_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
  output logic                          axil_rreq_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i,
  output w_state_e                      w_state,
  output r_state_e                      r_state
);

  localparam int          SW      = C_AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  RD_LAST = 3'(READ_LATENCY - 1);

  // Handshake rule: a beat transfers on a rising edge where valid && ready;
  // a source holds valid and payload until that edge, and every ready/valid
  // driven here is a register, so no input reaches an output combinationally.
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign b_hs  = s_axi_bvalid  && s_axi_bready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid  && s_axi_rready;

  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;

  w_state_e                w_state_d;
  logic                    aw_got, w_got, aw_got_d, w_got_d;
  logic                    awready_d, wready_d, bvalid_d, wpulse_d;
  logic [C_AXI_ADDR_WIDTH-1:0] waddr_d;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_d;
  logic [SW-1:0]               wstrb_d;

  always_comb begin
    w_state_d = w_state;
    aw_got_d  = aw_got;
    w_got_d   = w_got;
    awready_d = s_axi_awready;
    wready_d  = s_axi_wready;
    bvalid_d  = s_axi_bvalid;
    wpulse_d  = 1'b0;
    waddr_d   = axil_waddr_o;
    wdata_d   = axil_wdata_o;
    wstrb_d   = axil_wstrb_o;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          waddr_d   = s_axi_awaddr;
          aw_got_d  = 1'b1;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
          w_got_d  = 1'b1;
          wready_d = 1'b0;
        end
        if (aw_got_d && w_got_d) begin
          w_state_d = W_ISSUE;
          wpulse_d  = 1'b1;
        end
      end
      W_ISSUE: begin
        bvalid_d  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  r_state_e                    r_state_d;
  logic [2:0]                  rcnt, rcnt_d;
  logic                        arready_d, rvalid_d, rreq_d;
  logic [C_AXI_ADDR_WIDTH-1:0] raddr_d;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    r_state_d = r_state;
    rcnt_d    = rcnt;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rreq_d    = axil_rreq_o;
    raddr_d   = axil_raddr_o;
    rdata_d   = s_axi_rdata;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d   = s_axi_araddr;
          arready_d = 1'b0;
          rreq_d    = 1'b1;
          rcnt_d    = 3'd0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        // The core's data is valid during the last of the request cycles.
        if (rcnt == RD_LAST) begin
          rdata_d   = axil_rdata_i;
          rreq_d    = 1'b0;
          rvalid_d  = 1'b1;
          rcnt_d    = 3'd0;
          r_state_d = R_RESP;
        end else begin
          rcnt_d = rcnt + 3'd1;
        end
      end
      R_RESP: begin
        if (r_hs) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state       <= W_IDLE;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      axil_wready_o <= 1'b0;
      axil_waddr_o  <= '0;
      axil_wdata_o  <= '0;
      axil_wstrb_o  <= '0;
      r_state       <= R_IDLE;
      rcnt          <= 3'd0;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      axil_rreq_o   <= 1'b0;
      axil_raddr_o  <= '0;
      s_axi_rdata   <= '0;
    end else begin
      w_state       <= w_state_d;
      aw_got        <= aw_got_d;
      w_got         <= w_got_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      axil_wready_o <= wpulse_d;
      axil_waddr_o  <= waddr_d;
      axil_wdata_o  <= wdata_d;
      axil_wstrb_o  <= wstrb_d;
      r_state       <= r_state_d;
      rcnt          <= rcnt_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      axil_rreq_o   <= rreq_d;
      axil_raddr_o  <= raddr_d;
      s_axi_rdata   <= rdata_d;
    end
  end

endmodule
